// File: rtl/or_accum_pipe_if.sv
// Handshake bundle for or_accum_pipe: input beat stream with mode flags,
// frame clear, and the registered result stream.
interface or_accum_pipe_if #(
   parameter int WIDTH = 8,
   parameter int LANES = 4,
   parameter int CW    = 8
);
   logic                   in_valid;
   logic                   in_ready;
   logic [LANES*WIDTH-1:0] in_data;
   logic                   in_last;
   logic                   mode_acc;
   logic                   mode_inv;
   logic                   clr;
   logic                   out_valid;
   logic                   out_ready;
   logic [WIDTH-1:0]       out_data;
   logic                   out_any;
   logic [CW-1:0]          out_beats;

   modport master (
      output in_valid, in_data, in_last, mode_acc, mode_inv, clr, out_ready,
      input  in_ready, out_valid, out_data, out_any, out_beats
   );

   modport slave (
      input  in_valid, in_data, in_last, mode_acc, mode_inv, clr, out_ready,
      output in_ready, out_valid, out_data, out_any, out_beats
   );
endinterface

// File: rtl/or_accum_pipe.sv
// Two-stage multi-lane OR/NOR reducer with an optional sticky accumulator
// that collects beats until a last-flagged beat closes the frame.
module or_accum_pipe #(
   parameter int WIDTH = 8,
   parameter int LANES = 4,
   parameter int CW    = 8
) (
   input logic            clk,
   input logic            rst_n,
   or_accum_pipe_if.slave bus
);

   localparam logic [CW-1:0] CNT_MAX = {CW{1'b1}};
   localparam logic [CW-1:0] CNT_ONE = CW'(1);

   logic             adv;
   logic [WIDTH-1:0] lane_or;

   logic             s1_valid;
   logic [WIDTH-1:0] s1_data;
   logic             s1_last;
   logic             s1_acc;
   logic             s1_inv;

   logic [WIDTH-1:0] acc;
   logic [CW-1:0]    cnt;
   logic [WIDTH-1:0] acc_base;
   logic [CW-1:0]    cnt_base;
   logic [WIDTH-1:0] acc_next;
   logic [CW-1:0]    cnt_next;

   logic             out_valid;
   logic [WIDTH-1:0] out_data;
   logic             out_any;
   logic [CW-1:0]    out_beats;

   // The whole pipe stalls only when a result is waiting and not taken.
   assign adv          = !(out_valid && !bus.out_ready);
   assign bus.in_ready = adv;

   always_comb begin
      lane_or = '0;
      for (int i = 0; i < LANES; i++) begin
         lane_or = lane_or | bus.in_data[i*WIDTH +: WIDTH];
      end
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         s1_valid <= 1'b0;
         s1_data  <= '0;
         s1_last  <= 1'b0;
         s1_acc   <= 1'b0;
         s1_inv   <= 1'b0;
      end else if (adv) begin
         s1_valid <= bus.in_valid;
         if (bus.in_valid) begin
            s1_data <= lane_or;
            s1_last <= bus.in_last;
            s1_acc  <= bus.mode_acc;
            s1_inv  <= bus.mode_inv;
         end
      end
   end

   // A clear in the same cycle as an accumulating beat makes that beat the
   // first of a fresh frame, so the clear is applied before the OR/increment.
   always_comb begin
      acc_base = bus.clr ? '0 : acc;
      cnt_base = bus.clr ? '0 : cnt;
      acc_next = acc_base | s1_data;
      cnt_next = (cnt_base == CNT_MAX) ? CNT_MAX : cnt_base + CNT_ONE;
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         acc       <= '0;
         cnt       <= '0;
         out_valid <= 1'b0;
         out_data  <= '0;
         out_any   <= 1'b0;
         out_beats <= '0;
      end else if (adv) begin
         if (!s1_valid) begin
            out_valid <= 1'b0;
            acc       <= acc_base;
            cnt       <= cnt_base;
         end else if (!s1_acc) begin
            out_valid <= 1'b1;
            out_data  <= s1_inv ? ~s1_data : s1_data;
            out_any   <= |s1_data;
            out_beats <= CNT_ONE;
            acc       <= '0;
            cnt       <= '0;
         end else if (s1_last) begin
            out_valid <= 1'b1;
            out_data  <= s1_inv ? ~acc_next : acc_next;
            out_any   <= |acc_next;
            out_beats <= cnt_next;
            acc       <= '0;
            cnt       <= '0;
         end else begin
            out_valid <= 1'b0;
            acc       <= acc_next;
            cnt       <= cnt_next;
         end
      end
   end

   assign bus.out_valid = out_valid;
   assign bus.out_data  = out_data;
   assign bus.out_any   = out_any;
   assign bus.out_beats = out_beats;

endmodule
